// File: rtl/com_loader_if.sv
// rtl/com_loader_if.sv - stream input and data-memory write bundle for com_loader
//
// Purpose : groups the serial word stream coming in and the memory write
//           port going out, so the loader and its environment share one bundle.
// Signals : com_data_in / data_write_start / data_write_done  (stream, into loader)
//           mem_we / mem_addr / mem_wdata                    (memory write, out of loader)
// Modports: slave  - the loader side (consumes stream, drives memory writes)
//           master - the environment side (drives stream, observes memory writes)
interface com_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic [DATA_W-1:0] com_data_in;
    logic              data_write_start;
    logic              data_write_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  com_data_in, data_write_start, data_write_done,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output com_data_in, data_write_start, data_write_done,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/com_loader.sv
// rtl/com_loader.sv - matrix stream loader: header parse, memory write, length check
//
// Purpose : accepts the serial word stream, latches the P/Q/R header, writes
//           every accepted word to data memory from address 0 and checks the
//           stream length against 3 + P*Q + Q*R.
// Ports   : clk, rst_n (async active-low)
//           bus        - com_loader_if.slave (stream in, memory write out)
//           dim_p/q/r  - latched header words
//           word_count - number of words written so far
//           load_state - FSM state encoding
//           load_done  - load finished with matching length (level)
//           load_error - load failed (level)
module com_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    com_loader_if.slave       bus,
    output logic [DATA_W-1:0] dim_p,
    output logic [DATA_W-1:0] dim_q,
    output logic [DATA_W-1:0] dim_r,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        load_state,
    output logic              load_done,
    output logic              load_error
);
    localparam int EXP_W = 2 * DATA_W + 2;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BODY  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] data;
    logic              start, done;
    logic              prev_start, prev_done;
    logic [CNT_W-1:0]  acc_cnt;      // words accepted and queued for writing
    logic [EXP_W-1:0]  expected;
    logic [EXP_W-1:0]  exp_calc;
    logic              acc, start_rise, done_rise, fresh, in_load;
    logic              overflow, hdr_last, dims_zero;

    assign data  = bus.com_data_in;
    assign start = bus.data_write_start;
    assign done  = bus.data_write_done;

    assign acc        = (start && !done) || (done && !prev_done);
    assign start_rise = start && !prev_start;
    assign done_rise  = done && !prev_done;
    assign in_load    = (state == S_HDR) || (state == S_BODY);

    // A new stream begins either from IDLE or on a start rising edge in any
    // loading or terminal state; the word on that edge becomes header word 0.
    assign fresh = ((state == S_IDLE) && start) ||
                   (start_rise && (in_load || state == S_DONE || state == S_ERR));

    assign overflow = (acc_cnt == CNT_W'(MEM_DEPTH));
    assign hdr_last = (acc_cnt == CNT_W'(2));

    // The third header word is still on the bus when the length is computed,
    // so R comes straight from the stream rather than from dim_r.
    assign dims_zero = (dim_p == '0) || (dim_q == '0) || (data == '0);
    assign exp_calc  = EXP_W'(3) + EXP_W'(dim_p) * EXP_W'(dim_q)
                     + EXP_W'(dim_q) * EXP_W'(data);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_HDR;
            end
            S_HDR: begin
                if (start_rise) begin
                    next_state = S_HDR;
                end else if (acc) begin
                    if (hdr_last) begin
                        if (done_rise || dims_zero || (exp_calc > EXP_W'(MEM_DEPTH)))
                            next_state = S_ERR;
                        else
                            next_state = S_BODY;
                    end else if (done_rise) begin
                        next_state = S_ERR;
                    end
                end
            end
            S_BODY: begin
                if (start_rise) begin
                    next_state = S_HDR;
                end else if (acc) begin
                    if (overflow)       next_state = S_ERR;
                    else if (done_rise) next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                // Wait for the final write to land in word_count before comparing.
                if (!bus.mem_we)
                    next_state = (EXP_W'(word_count) == expected) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start_rise) next_state = S_HDR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        load_state = state;
        load_done  = (state == S_DONE);
        load_error = (state == S_ERR);
    end

    // Write path, counters and header latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_start    <= 1'b0;
            prev_done     <= 1'b0;
            acc_cnt       <= '0;
            word_count    <= '0;
            expected      <= '0;
            dim_p         <= '0;
            dim_q         <= '0;
            dim_r         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            prev_start <= start;
            prev_done  <= done;
            bus.mem_we <= 1'b0;
            if (fresh) begin
                // Any write still pending from an abandoned load is not counted.
                acc_cnt       <= acc ? CNT_W'(1) : '0;
                word_count    <= '0;
                expected      <= '0;
                dim_p         <= acc ? data : '0;
                dim_q         <= '0;
                dim_r         <= '0;
                bus.mem_we    <= acc;
                bus.mem_addr  <= '0;
                bus.mem_wdata <= data;
            end else begin
                if (bus.mem_we) word_count <= word_count + 1'b1;
                // The overflowing word is dropped, not written.
                if (in_load && acc && !((state == S_BODY) && overflow)) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= acc_cnt[ADDR_W-1:0];
                    bus.mem_wdata <= data;
                    acc_cnt       <= acc_cnt + 1'b1;
                    if (state == S_HDR) begin
                        case (acc_cnt[1:0])
                            2'd0:    dim_p <= data;
                            2'd1:    dim_q <= data;
                            default: dim_r <= data;
                        endcase
                        if (hdr_last) expected <= exp_calc;
                    end
                end
            end
        end
    end
endmodule
